fetch_queue_unit: RTL
=====================

// Module: fetch_queue_unit
// PURPOSE
//   Parametrised instruction-fetch front end: PC register, pipelined IMEM request/response
//   port with handshakes, in-order prefetch FIFO, and a valid/ready output to decode.
//   Redirects from branch/jump resolution flush queued and in-flight fetches.
//   Sits between the IMEM (or I-cache) and the decode/ID pipeline register.
// PARAMETERS
//   XLEN      32          PC / address width in bits
//   DEPTH     4           prefetch FIFO entries (power of 2, >=2)
//   MAX_OUT   2           max IMEM requests in flight (1..DEPTH)
//   RESET_PC  32'h0       PC value loaded on Reset (low 2 bits must be 0)
// PORTS
//   Clk            in   1     clock, all state updates on posedge
//   Reset          in   1     synchronous, active-high
//   Redirect       in   1     load RedirectPC and flush this cycle
//   RedirectPC     in   XLEN  new fetch PC; bits [1:0] ignored (forced 0)
//   imem_req_valid out  1     fetch request valid
//   imem_req_addr  out  XLEN  fetch address (word aligned)
//   imem_req_ready in   1     IMEM accepts request
//   imem_rsp_valid in   1     IMEM returns one instruction, in request order, >=1 cycle after accept
//   imem_rsp_data  in   32    instruction word
//   dec_valid      out  1     dec_instr/dec_pc valid
//   dec_instr      out  32    instruction at FIFO head
//   dec_pc         out  XLEN  PC of dec_instr
//   dec_ready      in   1     decode consumes head this cycle
// BEHAVIOUR
//   - Reset: pc_q=RESET_PC, rsp_pc=RESET_PC, FIFO empty, inflight=0, drop=0; all outputs 0
//     except imem_req_addr=RESET_PC. IMEM is reset by the same Reset and drops outstanding work.
//   - imem_req_valid = !Redirect && inflight<MAX_OUT && (count+inflight)<DEPTH; addr=pc_q.
//     Credit rule guarantees every kept response has a free FIFO slot; no rsp backpressure.
//   - Request accept (valid&ready): pc_q<=pc_q+4 (mod 2^XLEN wrap), inflight+1.
//   - Response: inflight-1. If drop>0: discard, drop-1. Else push {rsp_pc,data}, rsp_pc+=4.
//   - Accept and response in the same cycle: inflight unchanged.
//   - Pop on dec_valid&dec_ready. Push and pop same cycle (incl. full): count unchanged.
//   - dec_valid=(count!=0); head data registered, no rsp->dec bypass: response in cycle t
//     is visible to decode at t+1. Head held stable while dec_valid&!dec_ready.
//   - Redirect (highest priority over accept/push/pop): pc_q<=RedirectPC, rsp_pc<=RedirectPC,
//     FIFO emptied, drop<=inflight - (imem_rsp_valid?1:0), any response that cycle
//     discarded, no request issued that cycle. First redirected request issues at t+1.
//   - Redirect while drop>0: drop recomputed as above (covers all stale in-flight).
//   - Reset beats Redirect when both asserted.
//   - Counters: count 0..DEPTH, inflight 0..MAX_OUT, drop 0..MAX_OUT; never over/underflow.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined: adds output port perf_starve (32 bits) counting cycles with
//     dec_ready=1 and dec_valid=0, and perf_flush (32 bits) counting Redirect cycles; both
//     clear on Reset, saturate at all-ones.
//   Undefined: ports and counters absent; functional behaviour identical.
// TESTING
//   1 Reset, imem ready=1, 1-cycle latency, dec_ready=1 -> dec_pc 0,4,8,C... one per cycle
//     after fill; instructions in order.
//   2 dec_ready=0 for 20 cycles -> exactly DEPTH entries queued, imem_req_valid drops to 0,
//     no response lost; release -> DEPTH instrs drain back-to-back, then fetch resumes.
//   3 Two requests in flight, Redirect RedirectPC=0x100 -> both stale responses dropped,
//     next dec_pc=0x100, no stale instr ever reaches dec_valid.
//   4 Redirect coincident with imem_rsp_valid and dec pop, then second Redirect next cycle
//     to 0x200 -> only 0x200 stream emerges; drop reaches 0 exactly as last stale rsp returns.
//   5 imem_req_ready toggling randomly, 3-cycle latency -> imem_req_addr stable while
//     valid&!ready; PC stream strictly sequential; inflight<=MAX_OUT always.
//   6 RedirectPC=0xFFFFFFFC -> dec_pc 0xFFFFFFFC then 0x0 (wrap); Reset mid-stream ->
//     next cycle dec_valid=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit_if.sv
// Fetch-unit bus bundle: IMEM request/response channel plus the decode hand-off.
// master = fetch unit side, slave = IMEM/decode side.
interface fetch_queue_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            dec_valid;
    logic [31:0]     dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic            dec_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_instr, dec_pc,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_instr, dec_pc,
        output dec_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC, credit-limited IMEM requests, in-order prefetch FIFO.
// Optional macro FETCH_PERF_CNT_EN adds perf_starve / perf_flush saturating counters.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Redirect,
    input  logic [XLEN-1:0]    RedirectPC,
    fetch_queue_unit_if.master fq
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_starve,
    output logic [31:0]        perf_flush
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IF_W  = $clog2(MAX_OUT + 1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0]  pc_reg;
    logic [XLEN-1:0]  rsp_pc_reg;
    logic [CNT_W-1:0] count_reg;
    logic [IF_W-1:0]  inflight_reg;
    logic [IF_W-1:0]  drop_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;

    logic [XLEN+31:0] slot_data [DEPTH];
    logic [XLEN+31:0] head_data;
    logic [CNT_W:0]   occupancy;
    logic [XLEN-1:0]  redirect_target;
    logic             req_valid;
    logic             accept;
    logic             rsp_fire;
    logic             push;
    logic             pop;
    logic             dec_valid;

    // Queued entries plus outstanding requests form the credit pool, so every kept
    // response is guaranteed a free slot and the response channel needs no backpressure.
    assign occupancy       = {1'b0, count_reg} + (CNT_W + 1)'(inflight_reg);
    assign req_valid       = !Reset && !Redirect
                             && (inflight_reg < IF_W'(MAX_OUT))
                             && (occupancy < (CNT_W + 1)'(DEPTH));
    assign accept          = req_valid && fq.imem_req_ready;
    assign rsp_fire        = fq.imem_rsp_valid && (inflight_reg != '0);
    assign push            = rsp_fire && (drop_reg == '0) && !Redirect;
    assign dec_valid       = (count_reg != '0);
    assign pop             = dec_valid && fq.dec_ready && !Redirect;
    assign redirect_target = RedirectPC & ~XLEN'(3);

    assign head_data         = slot_data[rd_ptr_reg];
    assign fq.imem_req_valid = req_valid;
    assign fq.imem_req_addr  = pc_reg;
    assign fq.dec_valid      = dec_valid;
    assign fq.dec_pc         = dec_valid ? head_data[XLEN+31:32] : '0;
    assign fq.dec_instr      = dec_valid ? head_data[31:0] : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_reg       <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            count_reg    <= '0;
            inflight_reg <= '0;
            drop_reg     <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else if (Redirect) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            pc_reg       <= redirect_target;
            rsp_pc_reg   <= redirect_target;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            inflight_reg <= inflight_reg - IF_W'(rsp_fire);
            drop_reg     <= inflight_reg - IF_W'(rsp_fire);
        end else begin
            if (accept) begin
                pc_reg <= pc_reg + PC_STEP;
            end
            inflight_reg <= inflight_reg + IF_W'(accept) - IF_W'(rsp_fire);
            if (rsp_fire && (drop_reg != '0)) begin
                drop_reg <= drop_reg - IF_W'(1);
            end
            if (push) begin
                rsp_pc_reg <= rsp_pc_reg + PC_STEP;
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload slots carry no reset; the decode outputs are masked while the FIFO is empty.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [XLEN+31:0] entry_reg;
            always_ff @(posedge Clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= {rsp_pc_reg, fq.imem_rsp_data};
                end
            end
            assign slot_data[gi] = entry_reg;
        end
    endgenerate

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            perf_starve <= '0;
            perf_flush  <= '0;
        end else begin
            if (fq.dec_ready && !dec_valid && (perf_starve != '1)) begin
                perf_starve <= perf_starve + 32'd1;
            end
            if (Redirect && (perf_flush != '1)) begin
                perf_flush <= perf_flush + 32'd1;
            end
        end
    end
`endif
endmodule
